// File: rtl/phase_count_gen_if.sv
// Control/status bundle for phase_count_gen: enable, clear, tuning-word
// handshake and the phase ramp outputs.
interface phase_count_gen_if #(
  parameter int unsigned ACC_W = 16,
  parameter int unsigned OUT_W = 8
);
  logic             en;
  logic             phase_clr;
  logic [ACC_W-1:0] tw_in;
  logic             tw_load;
  logic             tw_ack;
  logic             tw_pending;
  logic [OUT_W-1:0] count;
  logic             wrap;

  modport master (
    output en, phase_clr, tw_in, tw_load,
    input  tw_ack, tw_pending, count, wrap
  );

  modport slave (
    input  en, phase_clr, tw_in, tw_load,
    output tw_ack, tw_pending, count, wrap
  );
endinterface

// File: rtl/phase_count_gen.sv
// Tuning-word phase accumulator producing the OUT_W-bit count ramp.
// Define PHASE_TW_IMMEDIATE_EN to apply tuning words on load instead of at a wrap.
module phase_count_gen #(
  parameter int unsigned ACC_W = 16,
  parameter int unsigned OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  phase_count_gen_if.slave bus
);

  typedef enum logic {IDLE, PEND} state_t;

  localparam logic [ACC_W-1:0] TW_RST = {{(ACC_W-1){1'b0}}, 1'b1} << (ACC_W - OUT_W);

  state_t           state_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] tw_act_q;
  logic [ACC_W-1:0] tw_nxt_q;
  logic             wrap_q, wrap_d;
  logic             tw_ack_q;
  logic [ACC_W:0]   sum;

  always_comb begin
    sum    = {1'b0, acc_q} + {1'b0, tw_act_q};
    acc_d  = acc_q;
    wrap_d = 1'b0;
    if (bus.phase_clr) begin
      acc_d  = '0;
      wrap_d = 1'b0;
    end else if (bus.en) begin
      acc_d  = sum[ACC_W-1:0];
      wrap_d = sum[ACC_W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      tw_act_q <= TW_RST;
      tw_nxt_q <= TW_RST;
      wrap_q   <= 1'b0;
      tw_ack_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      wrap_q   <= wrap_d;
      tw_ack_q <= 1'b0;
`ifdef PHASE_TW_IMMEDIATE_EN
      state_q <= IDLE;
      if (bus.tw_load) begin
        tw_act_q <= bus.tw_in;
        tw_nxt_q <= bus.tw_in;
        tw_ack_q <= 1'b1;
      end
`else
      case (state_q)
        IDLE: begin
          if (bus.tw_load) begin
            tw_nxt_q <= bus.tw_in;
            state_q  <= PEND;
          end
        end
        PEND: begin
          // Apply takes the old tw_nxt; a coincident load re-arms PEND with tw_in.
          if (bus.phase_clr || (bus.en && sum[ACC_W])) begin
            tw_act_q <= tw_nxt_q;
            tw_ack_q <= 1'b1;
            if (!bus.tw_load) state_q <= IDLE;
          end
          if (bus.tw_load) tw_nxt_q <= bus.tw_in;
        end
        default: state_q <= IDLE;
      endcase
`endif
    end
  end

  assign bus.count      = acc_q[ACC_W-1 -: OUT_W];
  assign bus.wrap       = wrap_q;
  assign bus.tw_ack     = tw_ack_q;
  assign bus.tw_pending = (state_q == PEND);

endmodule

// File: tb/tb_phase_count_gen.sv
// Directed bench for phase_count_gen: a reference model pushes expected outputs
// to a queue each cycle, popped and compared one clock later.
module tb_phase_count_gen;

  typedef struct packed {
    logic [7:0] count;
    logic       wrap;
    logic       ack;
    logic       pend;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   n_ack;
  exp_t sb[$];

  logic [15:0] m_acc, m_act, m_nxt;
  logic        m_wrap, m_ack, m_pend;

  logic [7:0] obs_count;
  logic       obs_wrap, obs_ack, obs_pend;

  phase_count_gen_if #(.ACC_W(16), .OUT_W(8)) bus ();

  phase_count_gen #(.ACC_W(16), .OUT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc  = 16'h0000;
    m_act  = 16'h0100;
    m_nxt  = 16'h0100;
    m_wrap = 1'b0;
    m_ack  = 1'b0;
    m_pend = 1'b0;
  endtask

  // One clock: drive inputs, predict, then compare after the edge.
  task automatic step(input logic e, input logic c, input logic l, input logic [15:0] w);
    logic [16:0] s;
    logic        apply;
    exp_t        x;
    bus.en        = e;
    bus.phase_clr = c;
    bus.tw_load   = l;
    bus.tw_in     = w;
    s     = {1'b0, m_acc} + {1'b0, m_act};
    apply = m_pend && (c || (e && s[16]));
    if (c) begin
      m_acc  = 16'h0000;
      m_wrap = 1'b0;
    end else if (e) begin
      m_acc  = s[15:0];
      m_wrap = s[16];
    end else begin
      m_wrap = 1'b0;
    end
    m_ack = apply;
    if (apply) m_act = m_nxt;
    if (l) begin
      m_nxt  = w;
      m_pend = 1'b1;
    end else if (apply) begin
      m_pend = 1'b0;
    end
    x.count = m_acc[15:8];
    x.wrap  = m_wrap;
    x.ack   = m_ack;
    x.pend  = m_pend;
    sb.push_back(x);
    @(posedge clk);
    #1;
    obs_count = bus.count;
    obs_wrap  = bus.wrap;
    obs_ack   = bus.tw_ack;
    obs_pend  = bus.tw_pending;
    if (obs_ack) n_ack++;
    check("sb_depth", 32'(sb.size()), 32'd1);
    if (sb.size() != 0) begin
      x = sb.pop_front();
      check("sb_count", 32'(obs_count), 32'(x.count));
      check("sb_wrap",  32'(obs_wrap),  32'(x.wrap));
      check("sb_ack",   32'(obs_ack),   32'(x.ack));
      check("sb_pend",  32'(obs_pend),  32'(x.pend));
    end
    bus.tw_load   = 1'b0;
    bus.phase_clr = 1'b0;
  endtask

  task automatic run_until_count(input logic [7:0] target, input int bound);
    int k;
    k = 0;
    while (obs_count != target && k < bound) begin
      step(1'b1, 1'b0, 1'b0, 16'h0000);
      k++;
    end
    check("reach_count", 32'(obs_count), 32'(target));
  endtask

  task automatic run_until_wrap(input int bound, output int steps);
    steps = 0;
    do begin
      step(1'b1, 1'b0, 1'b0, 16'h0000);
      steps++;
    end while (!obs_wrap && steps < bound);
    check("reach_wrap", 32'(obs_wrap), 32'd1);
  endtask

  initial begin
    int n;
    n_checks = 0;
    n_fail   = 0;
    n_ack    = 0;
    obs_count = '0;
    obs_wrap  = 1'b0;
    obs_ack   = 1'b0;
    obs_pend  = 1'b0;
    rst           = 1'b0;
    bus.en        = 1'b0;
    bus.phase_clr = 1'b0;
    bus.tw_load   = 1'b0;
    bus.tw_in     = '0;
    model_reset();

    #12;
    check("rst_count", 32'(bus.count), 32'h0);
    check("rst_wrap",  32'(bus.wrap), 32'h0);
    check("rst_ack",   32'(bus.tw_ack), 32'h0);
    check("rst_pend",  32'(bus.tw_pending), 32'h0);
    rst = 1'b1;

    // Free-running ramp: 256 steps back to 0 with one wrap.
    for (int i = 1; i <= 256; i++) begin
      step(1'b1, 1'b0, 1'b0, 16'h0000);
      check("ramp_count", 32'(obs_count), 32'(i % 256));
      check("ramp_wrap",  32'(obs_wrap), (i == 256) ? 32'd1 : 32'd0);
    end

    // Enable low holds the phase.
    run_until_count(8'h42, 80);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0, 16'h0000);
      check("hold_count", 32'(obs_count), 32'h42);
      check("hold_wrap",  32'(obs_wrap), 32'h0);
      check("hold_ack",   32'(obs_ack), 32'h0);
    end
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    check("resume_count", 32'(obs_count), 32'h43);

    // Load 0x0400 at count 0x10, applied at the wrap.
    run_until_count(8'h10, 300);
    step(1'b1, 1'b0, 1'b1, 16'h0400);
    check("ld4_pend",  32'(obs_pend), 32'd1);
    check("ld4_count", 32'(obs_count), 32'h11);
    run_until_wrap(300, n);
    check("ld4_wrap_count", 32'(obs_count), 32'h0);
    check("ld4_wrap_ack",   32'(obs_ack), 32'd1);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    check("ld4_step4", 32'(obs_count), 32'h4);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    check("ld4_step8", 32'(obs_count), 32'h8);
    run_until_wrap(100, n);
    check("ld4_period", 32'(n + 2), 32'd64);

    // Two loads while pending: only the last one is applied, one ack.
    step(1'b1, 1'b0, 1'b1, 16'h0200);
    step(1'b1, 1'b0, 1'b1, 16'h0800);
    n_ack = 0;
    run_until_wrap(100, n);
    check("dbl_ack_count", 32'(n_ack), 32'd1);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    check("dbl_step8", 32'(obs_count), 32'h8);

    // phase_clr while pending applies the word immediately.
    run_until_count(8'h78, 40);
    step(1'b1, 1'b0, 1'b1, 16'h0300);
    check("clr_pre_count", 32'(obs_count), 32'h80);
    check("clr_pre_pend",  32'(obs_pend), 32'd1);
    step(1'b1, 1'b1, 1'b0, 16'h0000);
    check("clr_count", 32'(obs_count), 32'h0);
    check("clr_wrap",  32'(obs_wrap), 32'd0);
    check("clr_ack",   32'(obs_ack), 32'd1);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    check("clr_step3", 32'(obs_count), 32'h3);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    check("clr_step6", 32'(obs_count), 32'h6);

    // Async reset mid-pending at count 0xF0.
    step(1'b1, 1'b0, 1'b1, 16'h0100);
    run_until_count(8'hF0, 100);
    check("arst_pre_pend", 32'(obs_pend), 32'd1);
    #3;
    rst = 1'b0;
    #1;
    check("arst_count", 32'(bus.count), 32'h0);
    check("arst_pend",  32'(bus.tw_pending), 32'h0);
    check("arst_ack",   32'(bus.tw_ack), 32'h0);
    model_reset();
    #3;
    rst = 1'b1;
    n_ack = 0;
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    check("arst_step1", 32'(obs_count), 32'h1);
    for (int i = 0; i < 260; i++) step(1'b1, 1'b0, 1'b0, 16'h0000);
    check("arst_no_ack", 32'(n_ack), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/phase_count_gen.md
# phase_count_gen

Programmable phase-accumulator stage that generates the 8-bit `count` ramp driving the waveform generators (sine, square, sawtooth, rhomboid, rectified, modulated square). It replaces the free-running 0..255 counter with a tuning-word-controlled accumulator, so output frequency is set at run time. Tuning-word updates are handshaked and, by default, applied only at a ramp wrap so the downstream waveform stays phase-continuous.

## Interface
Parameters:
- `ACC_W`, 16: accumulator width in bits; must be ≥ `OUT_W`.
- `OUT_W`, 8: width of `count`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  accumulate enable; when low, all state holds.
- `phase_clr`  in  1  synchronous clear of the accumulator.
- `tw_in`  in  ACC_W  new tuning word (phase step per clock).
- `tw_load`  in  1  one-cycle request to capture `tw_in`.
- `tw_ack`  out  1  one-cycle pulse: the pending word became active.
- `tw_pending`  out  1  a captured word is waiting to be applied.
- `count`  out  OUT_W  phase, i.e. `acc[ACC_W-1 -: OUT_W]`; drives the waveform generators.
- `wrap`  out  1  one-cycle pulse: the accumulator overflowed on this update.

## Operation
- Registers: `acc` (ACC_W), `tw_act` (ACC_W), `tw_nxt` (ACC_W), FSM state.
- Reset values: `acc`=0, `tw_act`=`tw_nxt`=`1<<(ACC_W-OUT_W)`, so `count` steps by 1 per clock. Outputs: `count`=0, `wrap`=0, `tw_ack`=0, `tw_pending`=0. State is IDLE.
- Accumulate: when `en`=1, `{carry, acc} <= acc + tw_act` (ACC_W+1-bit sum). The carry is discarded from `acc` (modulo 2^ACC_W) and is registered into `wrap`.
- FSM with two states:
  - IDLE: when `tw_load`=1, `tw_nxt`<=`tw_in` and go to PEND.
  - PEND: `tw_pending`=1. A further `tw_load` overwrites `tw_nxt` and the FSM stays in PEND; only the last word is applied. When an accumulate update produces carry=1: `tw_act`<=`tw_nxt`, pulse `tw_ack`, go to IDLE. The new word is first used on the following update.
- `phase_clr`=1 has priority over accumulation, regardless of `en`:
  - `acc`<=0 and `wrap`<=0.
  - In PEND, the pending word is applied immediately with `tw_ack`.
- Simultaneous `tw_load` and apply in PEND: the apply uses the old `tw_nxt`. The new `tw_in` is captured into `tw_nxt` and the FSM stays in PEND.
- `tw_in`=0 is legal: `count` freezes and no wrap occurs. A pending word then waits for `phase_clr`.
- `en`=0 holds `acc`. `wrap` and `tw_ack` are forced to 0. `tw_load` captures still occur.

## Timing
- `count`, `wrap`, `tw_ack`, `tw_pending` are all registered outputs with no combinational paths from inputs.
- The update at edge N is visible after edge N. `wrap` is high in the same cycle `count` shows the post-overflow value.
- Tuning word to output: `tw_load` at edge N gives `tw_pending`=1 after N. Apply happens at the first wrap edge M > N, and the new step is first seen at edge M+1.
- Async reset mid-operation: all registers go to reset values immediately. The pending word is lost, with no `tw_ack`.

## Configuration
- `PHASE_TW_IMMEDIATE_EN`:
  - Defined: PEND is bypassed. `tw_load` writes `tw_act` directly, and `tw_ack` pulses on the next clock regardless of wrap. `tw_pending` is tied to 0.
  - Undefined (default): wrap-synchronised apply, as described above.

## Test plan
- Reset release, `en`=1, no load: `count` runs 0,1,…,255,0. `wrap` pulses exactly when `count` returns to 0, every 256 cycles.
- `tw_load` with `tw_in`=0x0400 at `count`=0x10: `tw_pending`=1. Step stays 1 until the wrap to 0, then `tw_ack` pulses and the sequence continues 0,4,8,…; wrap period is 64 cycles.
- Two loads in PEND (0x0200, then 0x0800): only 0x0800 is applied at the wrap, with exactly one `tw_ack`.
- `phase_clr` at `count`=0x80 while PEND holds 0x0300: next `count`=0, `wrap`=0, `tw_ack`=1. The sequence is then 0,3,6,….
- `en` low for 10 cycles at `count`=0x42: `count` holds 0x42, and `wrap` and `tw_ack` stay 0. It resumes at 0x43.
- Async reset asserted mid-PEND with `count`=0xF0: immediate `count`=0 and `tw_pending`=0. After release, step is 1 and no `tw_ack` occurs.
